encoder_rr: RTL and testbench

- Sequential N-to-W round-robin request encoder; the inverse of the 2-to-4 decoder.
- Captures request lines into a sticky pending register and grants one pending index at a time as a W-bit binary code.
- Grant uses a valid/ready handshake.
- Sits where several one-hot request sources must be serialised into an encoded index for a downstream consumer.

---
 rtl/encoder_rr_pkg.sv | 10 +
 rtl/encoder_rr_pick.sv | 31 +++
 rtl/encoder_rr.sv | 82 ++++++++
 tb/tb_encoder_rr.sv | 128 ++++++++++++
 4 files changed

// File: rtl/encoder_rr_pkg.sv
// Shared defaults and FSM state encoding for the round-robin request encoder.
package encoder_rr_pkg;
   localparam int ENC_N = 4;
   localparam int ENC_W = 2;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_e;
endpackage

// File: rtl/encoder_rr_pick.sv
// Circular first-set search: lowest set bit of v at or after index p, wrapping mod N.
module rr_pick
   import encoder_rr_pkg::*;
#(
   parameter int N = ENC_N,
   parameter int W = ENC_W
) (
   input  logic [N-1:0] v,
   input  logic [W-1:0] p,
   output logic [W-1:0] idx
);

   // rot[k] is v rotated so that bit p lands at position 0.
   logic [N-1:0] rot;

   genvar gi;
   for (gi = 0; gi < N; gi++) begin : g_rot
      localparam logic [W-1:0] OFF = W'(gi);
      logic [W-1:0] pos;
      assign pos     = p + OFF;
      assign rot[gi] = v[pos];
   end

   always_comb begin
      idx = p;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) idx = p + W'(k);
      end
   end

endmodule

// File: rtl/encoder_rr.sv
// Sequential N-to-W round-robin request encoder with a sticky pending register
// and a valid/ready grant handshake.
module encoder_rr
   import encoder_rr_pkg::*;
#(
   parameter int N = ENC_N,
   parameter int W = ENC_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] din,
   input  logic         ready,
   output logic [W-1:0] dout,
   output logic         valid,
   output logic [N-1:0] pend
);

   state_e       state_q, state_d;
   logic [N-1:0] pend_q, pend_d;
   logic [W-1:0] ptr_q, ptr_d;
   logic [W-1:0] dout_q, dout_d;

   logic         fire;
   logic [N-1:0] cur_onehot, rest, pick_v;
   logic [W-1:0] pick_p, pick_idx;

   assign fire       = (state_q == S_GRANT) && ready;
   assign cur_onehot = N'(1) << dout_q;
   // Remaining requests once the current grant is taken; this cycle's din is excluded.
   assign rest       = pend_q & ~cur_onehot;

   assign pend_d = (pend_q & ~(fire ? cur_onehot : '0)) | din;
   assign ptr_d  = fire ? dout_q + W'(1) : ptr_q;

   assign pick_v = (state_q == S_IDLE) ? pend_q : rest;
   assign pick_p = (state_q == S_IDLE) ? ptr_q  : dout_q + W'(1);

   rr_pick #(.N(N), .W(W)) u_pick (
      .v   (pick_v),
      .p   (pick_p),
      .idx (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      dout_d  = dout_q;
      case (state_q)
         S_IDLE: begin
            if (|pend_q) begin
               dout_d  = pick_idx;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            if (ready) begin
               if (|rest) dout_d  = pick_idx;
               else       state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pend_q  <= '0;
         ptr_q   <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         ptr_q   <= ptr_d;
         dout_q  <= dout_d;
      end
   end

   assign dout  = dout_q;
   assign valid = (state_q == S_GRANT);
   assign pend  = pend_q;

endmodule

// File: tb/tb_encoder_rr.sv
// Directed bench for encoder_rr: reset, single grant, burst, backpressure,
// fairness and asynchronous reset mid-grant.
module tb_encoder_rr;
   logic       clk;
   logic       rst;
   logic [3:0] din;
   logic       ready;
   logic [1:0] dout;
   logic       valid;
   logic [3:0] pend;

   int n_assert = 0;
   int n_fail   = 0;

   encoder_rr dut (
      .clk   (clk),
      .rst   (rst),
      .din   (din),
      .ready (ready),
      .dout  (dout),
      .valid (valid),
      .pend  (pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [1:0] d, input logic [3:0] p);
      chk({tag, ".valid"}, {7'd0, valid}, {7'd0, v});
      chk({tag, ".dout"},  {6'd0, dout},  {6'd0, d});
      chk({tag, ".pend"},  {4'd0, pend},  {4'd0, p});
      $display("%s: din=%b ready=%b -> valid=%b dout=%b pend=%b", tag, din, ready, valid, dout, pend);
   endtask

   initial begin
      // 1. Reset with requests present: nothing may be captured.
      rst = 1'b1; din = 4'b1111; ready = 1'b0;
      #1;
      chk_out("rst0", 1'b0, 2'b00, 4'b0000);
      tick(); chk_out("rst1", 1'b0, 2'b00, 4'b0000);
      tick(); chk_out("rst2", 1'b0, 2'b00, 4'b0000);
      rst = 1'b0; din = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         tick(); chk_out("post_rst_idle", 1'b0, 2'b00, 4'b0000);
      end

      // 2. Single request, ready high while idle is ignored.
      din = 4'b0100; ready = 1'b1;
      tick(); chk_out("single_capture", 1'b0, 2'b00, 4'b0100);
      din = 4'b0000;
      tick(); chk_out("single_grant", 1'b1, 2'b10, 4'b0100);
      tick(); chk_out("single_done", 1'b0, 2'b10, 4'b0000);

      // Pointer is now 3; reset so the burst starts from ptr=0.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_out("rst_before_burst", 1'b0, 2'b00, 4'b0000);

      // 3. Burst of all four requests, back-to-back grants.
      din = 4'b1111; ready = 1'b1;
      tick(); chk_out("burst_capture", 1'b0, 2'b00, 4'b1111);
      din = 4'b0000;
      tick(); chk_out("burst_g0", 1'b1, 2'b00, 4'b1111);
      tick(); chk_out("burst_g1", 1'b1, 2'b01, 4'b1110);
      tick(); chk_out("burst_g2", 1'b1, 2'b10, 4'b1100);
      tick(); chk_out("burst_g3", 1'b1, 2'b11, 4'b1000);
      tick(); chk_out("burst_done", 1'b0, 2'b11, 4'b0000);

      // 4. Backpressure: grant held while ready low, new request accumulates.
      din = 4'b0010; ready = 1'b0;
      tick(); chk_out("bp_capture", 1'b0, 2'b11, 4'b0010);
      din = 4'b0000;
      tick(); chk_out("bp_hold0", 1'b1, 2'b01, 4'b0010);
      tick(); chk_out("bp_hold1", 1'b1, 2'b01, 4'b0010);
      din = 4'b1000;
      tick(); chk_out("bp_hold2", 1'b1, 2'b01, 4'b1010);
      din = 4'b0000;
      tick(); chk_out("bp_hold3", 1'b1, 2'b01, 4'b1010);
      tick(); chk_out("bp_hold4", 1'b1, 2'b01, 4'b1010);
      ready = 1'b1;
      tick(); chk_out("bp_g3", 1'b1, 2'b11, 4'b1000);
      tick(); chk_out("bp_done", 1'b0, 2'b11, 4'b0000);

      // 5. Fairness: two requesters held high alternate without starvation.
      din = 4'b0011; ready = 1'b1;
      tick(); chk_out("fair_capture", 1'b0, 2'b11, 4'b0011);
      for (int i = 0; i < 6; i++) begin
         tick(); chk_out("fair_alt", 1'b1, (i % 2 == 0) ? 2'b00 : 2'b01, 4'b0011);
      end
      din = 4'b0000;
      tick(); chk_out("fair_drain", 1'b1, 2'b00, 4'b0001);
      tick(); chk_out("fair_done", 1'b0, 2'b00, 4'b0000);

      // 6. Asynchronous reset between edges while a grant is outstanding (ptr=1).
      din = 4'b0110; ready = 1'b0;
      tick(); chk_out("arst_capture", 1'b0, 2'b00, 4'b0110);
      din = 4'b0000;
      tick(); chk_out("arst_grant", 1'b1, 2'b01, 4'b0110);
      #2;
      rst = 1'b1;
      #1;
      chk_out("arst_immediate", 1'b0, 2'b00, 4'b0000);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); chk_out("arst_after", 1'b0, 2'b00, 4'b0000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
